// File: rtl/button_pkg.sv
// Shared constants, repeat-state encoding and elaboration-time helpers for the button debouncer.
package button_pkg;

    localparam int unsigned DEF_CHANNELS      = 5;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_DEBOUNCE_BITS = 16;
    localparam int unsigned DEF_REPEAT_EN     = 0;
    localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
    localparam int unsigned DEF_REPEAT_PERIOD = 10000000;

    // Auto-repeat progress of one held button.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Number of bits needed to index 'value' distinct states.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_array_channel.sv
// One button: synchroniser, symmetric debounce counter, edge pulses and optional auto-repeat.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
    parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic in_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_c
);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic [SYNC_STAGES-1:0]   sync_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q;
    logic [DEBOUNCE_BITS-1:0] cnt_d;
    logic                     level_q;
    logic                     level_d;
    logic                     press_q;
    logic                     press_d;
    logic                     release_q;
    logic                     release_d;
    logic                     rpt_fire_c;

    // Shift the raw level through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    end

    // Count consecutive disagreement cycles; flip the level once the counter saturates.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (&cnt_q) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_BITS'(1);
            end
        end
    end

    // Edge pulses are derived from the next level so they align with the level change.
    always_comb begin
        press_d   = (level_d & ~level_q) | rpt_fire_c;
        release_d = ~level_d & level_q;
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    if (REPEAT_EN != 0) begin : g_rpt
        localparam int unsigned RCNT_W = clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

        rpt_state_e        state_q;
        logic [RCNT_W-1:0] rcnt_q;
        logic              delay_done_c;
        logic              period_done_c;

        assign delay_done_c  = (rcnt_q == RCNT_W'(REPEAT_DELAY - 1));
        assign period_done_c = (rcnt_q == RCNT_W'(REPEAT_PERIOD - 1));

        // A falling level wins, so a repeat pulse never lands on the release edge.
        assign rpt_fire_c = level_d & (((state_q == DELAY) & delay_done_c) |
                                       ((state_q == REPEAT) & period_done_c));

        // Repeat FSM: press edge arms DELAY, then periodic pulses until release.
        always_ff @(posedge clock) begin
            if (reset || !level_d) begin
                state_q <= IDLE;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!level_q) begin
                            state_q <= DELAY;
                            rcnt_q  <= '0;
                        end
                    end
                    DELAY: begin
                        if (delay_done_c) begin
                            state_q <= REPEAT;
                            rcnt_q  <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + RCNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (period_done_c) begin
                            rcnt_q <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + RCNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end else begin : g_no_rpt
        assign rpt_fire_c = 1'b0;
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_c = press_d;

endmodule

// File: rtl/button_debounce_array.sv
// Array of independent debounced buttons with a combined registered press flag.
module button_debounce_array
    import button_pkg::*;
#(
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
    parameter int unsigned REPEAT_EN     = DEF_REPEAT_EN,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic                any_press_o
);

    logic [CHANNELS-1:0] press_next_c;
    logic                any_press_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        button_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_BITS(DEBOUNCE_BITS),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .in_i        (in_i[g]),
            .level_o     (level_o[g]),
            .press_o     (press_o[g]),
            .release_o   (release_o[g]),
            .press_next_c(press_next_c[g])
        );
    end

    // Register the OR of next-cycle presses so it lines up with the press bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next_c;
        end
    end

    assign any_press_o = any_press_q;

endmodule

// File: tb/tb_button_debounce_array.sv
// Scoreboard bench: a window-based reference model predicts outputs of a plain and an auto-repeat instance.
module tb_button_debounce_array;

    localparam int unsigned CH  = 2;
    localparam int unsigned SS  = 2;
    localparam int unsigned DB  = 2;
    localparam int unsigned WIN = 4;   // 2**DB consecutive disagreeing samples
    localparam int          RD  = 5;
    localparam int          RP  = 3;

    logic          clock;
    logic          reset;
    logic [CH-1:0] in_s;

    logic [CH-1:0] lvl_nr, prs_nr, rel_nr;
    logic          any_nr;
    logic [CH-1:0] lvl_rp, prs_rp, rel_rp;
    logic          any_rp;

    button_debounce_array #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_BITS(DB),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_nr (
        .clock(clock), .reset(reset), .in_i(in_s),
        .level_o(lvl_nr), .press_o(prs_nr), .release_o(rel_nr), .any_press_o(any_nr)
    );

    button_debounce_array #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_BITS(DB),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_rp (
        .clock(clock), .reset(reset), .in_i(in_s),
        .level_o(lvl_rp), .press_o(prs_rp), .release_o(rel_rp), .any_press_o(any_rp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] rel;
        logic [CH-1:0] prs_nr;
        logic [CH-1:0] prs_rp;
        logic          any_nr;
        logic          any_rp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: newest sample at bit 0; a level flips once the synchronised
    // samples (SS edges old) have disagreed with it for WIN consecutive edges.
    logic [SS+WIN-1:0] hist   [CH];
    logic              m_lvl  [CH];
    int                rise_t [CH];

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %b, want %b", name, cyc, act, req);
    endtask

    task automatic model_step();
        exp_t e;
        bit   all_diff;
        int   d;
        e = '0;
        cyc++;
        for (int ch = 0; ch < CH; ch++) begin
            if (reset) begin
                hist[ch]   = '0;
                m_lvl[ch]  = 1'b0;
                rise_t[ch] = -1;
            end else begin
                hist[ch] = {hist[ch][SS+WIN-2:0], in_s[ch]};
                all_diff = 1'b1;
                for (int j = SS; j < SS + WIN; j++) begin
                    if (hist[ch][j] == m_lvl[ch]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[ch] = ~m_lvl[ch];
                    if (m_lvl[ch]) begin
                        e.prs_nr[ch] = 1'b1;
                        e.prs_rp[ch] = 1'b1;
                        rise_t[ch]   = cyc;
                    end else begin
                        e.rel[ch]  = 1'b1;
                        rise_t[ch] = -1;
                    end
                end else if (m_lvl[ch] && rise_t[ch] >= 0) begin
                    d = cyc - rise_t[ch];
                    if (d == RD || (d > RD && ((d - RD) % RP) == 0)) e.prs_rp[ch] = 1'b1;
                end
            end
            e.lvl[ch] = m_lvl[ch];
        end
        e.any_nr = |e.prs_nr;
        e.any_rp = |e.prs_rp;
        exp_q.push_back(e);
    endtask

    // One clock: model consumes the inputs seen at this edge, then inputs may change.
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic hold(input logic [CH-1:0] v, input int n);
        in_s = v;
        repeat (n) tick();
    endtask

    // Monitor: every cycle the DUTs present a full output set; compare against the queue.
    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty cycle %0d: got no expectation, want one", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("level_nr",   lvl_nr,            mon_e.lvl);
                check("press_nr",   prs_nr,            mon_e.prs_nr);
                check("release_nr", rel_nr,            mon_e.rel);
                check("any_nr",     {1'b0, any_nr},    {1'b0, mon_e.any_nr});
                check("level_rp",   lvl_rp,            mon_e.lvl);
                check("press_rp",   prs_rp,            mon_e.prs_rp);
                check("release_rp", rel_rp,            mon_e.rel);
                check("any_rp",     {1'b0, any_rp},    {1'b0, mon_e.any_rp});
            end
        end
    end

    initial begin
        int unsigned flip_div;
        for (int ch = 0; ch < CH; ch++) begin
            hist[ch]   = '0;
            m_lvl[ch]  = 1'b0;
            rise_t[ch] = -1;
        end
        reset = 1'b1;
        in_s  = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Directed scenarios
        hold(2'b00, 4);
        hold(2'b01, 12);                        // clean press on channel 0
        hold(2'b00, 12);                        // clean release
        repeat (4) begin                        // 3-cycle glitches never pass
            hold(2'b01, 3);
            hold(2'b00, 3);
        end
        hold(2'b01, 25);                        // long hold: repeat pulses
        hold(2'b00, 10);
        hold(2'b11, 12);                        // simultaneous press
        reset = 1'b1;                           // reset while held
        repeat (2) tick();
        reset = 1'b0;
        hold(2'b11, 10);
        hold(2'b00, 10);
        hold(2'b10, 4);                         // channel 1 alone, short then long
        hold(2'b00, 2);
        hold(2'b10, 20);
        hold(2'b01, 20);                        // swap channels on one edge

        // Randomised segments with varying bounce density
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 2))
                0:       flip_div = 3;
                1:       flip_div = 8;
                default: flip_div = 30;
            endcase
            for (int c = 0; c < 100; c++) begin
                for (int ch = 0; ch < CH; ch++) begin
                    if ($urandom_range(0, flip_div - 1) == 0) in_s[ch] = ~in_s[ch];
                end
                reset = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        reset = 1'b0;
        hold(2'b00, 10);

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
